// File: rtl/mmu_pkg.sv
// Shared types and constants for the paging controller and its translation cache.
package mmu_pkg;
    typedef enum logic [2:0] {IDLE, WALK, WALK_WAIT, ACCESS, READ_WAIT, RESP} state_t;

    localparam int PTE_V   = 1;
    localparam int PTE_W   = 0;
    localparam int PPN_LSB = 2;

    localparam logic CFG_BPR = 1'b0;
    localparam logic CFG_PG  = 1'b1;
endpackage

// File: rtl/mmu_tlb1.sv
// Single-entry translation cache: one VPN tag plus the PTE it maps to.
module mmu_tlb1 #(
    parameter int VPNW = 2,
    parameter int DW   = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [VPNW-1:0] lk_vpn,
    output logic            hit,
    output logic [DW-1:0]   pte,
    input  logic            ld,
    input  logic [VPNW-1:0] ld_vpn,
    input  logic [DW-1:0]   ld_pte,
    input  logic            inv
);
    logic            valid_q, valid_d;
    logic [VPNW-1:0] tag_q, tag_d;
    logic [DW-1:0]   pte_q, pte_d;

    // A fill belongs to a walk already in flight, so it takes precedence over a flush.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        pte_d   = pte_q;
        if (ld) begin
            valid_d = 1'b1;
            tag_d   = ld_vpn;
            pte_d   = ld_pte;
        end else if (inv) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            pte_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            pte_q   <= pte_d;
        end
    end

    assign hit = valid_q && (tag_q == lk_vpn);
    assign pte = pte_q;
endmodule

// File: rtl/page_walk_ctrl.sv
// Paging controller: sequences PTE fetch and data access on one synchronous-read memory port.
module page_walk_ctrl
    import mmu_pkg::*;
#(
    parameter int DW   = 6,
    parameter int VAW  = 6,
    parameter int PAW  = 8,
    parameter int OFFW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req,
    input  logic           we,
    input  logic [VAW-1:0] vaddr,
    input  logic [DW-1:0]  wdata,
    output logic           ack,
    output logic           fault,
    output logic [DW-1:0]  rdata,
    input  logic           cfg_we,
    input  logic           cfg_sel,
    input  logic [DW-1:0]  cfg_wdata,
    input  logic           tlb_flush,
    output logic           pg,
    output logic           busy,
    output logic [PAW-1:0] mem_addr,
    output logic           mem_rd,
    output logic           mem_wr,
    output logic [DW-1:0]  mem_wdata,
    input  logic [DW-1:0]  mem_rdata
);
    localparam int VPNW = VAW - OFFW;
    localparam int BPRW = PAW - VAW + OFFW;

    state_t         state_q, state_d;
    logic [VAW-1:0] va_q, va_d;
    logic           we_q, we_d;
    logic [DW-1:0]  wd_q, wd_d;
    logic [BPRW-1:0] bpr_q, bpr_d;
    logic           pg_q, pg_d;
    logic           ack_q, ack_d;
    logic           fault_q, fault_d;
    logic [DW-1:0]  rdata_q, rdata_d;
    logic [PAW-1:0] mem_addr_q, mem_addr_d;
    logic           mem_rd_q, mem_rd_d;
    logic           mem_wr_q, mem_wr_d;
    logic [DW-1:0]  mem_wdata_q, mem_wdata_d;
    logic           busy_q, busy_d;

    logic           tlb_hit_raw, tlb_hit, tlb_ld, tlb_inv;
    logic [DW-1:0]  tlb_pte;
    logic           acc;
    logic [PAW-1:0] acc_addr;

    mmu_tlb1 #(.VPNW(VPNW), .DW(DW)) u_tlb (
        .clk    (clk),
        .rst    (rst),
        .lk_vpn (vaddr[VAW-1:OFFW]),
        .hit    (tlb_hit_raw),
        .pte    (tlb_pte),
        .ld     (tlb_ld),
        .ld_vpn (va_q[VAW-1:OFFW]),
        .ld_pte (mem_rdata),
        .inv    (tlb_inv)
    );

    assign tlb_hit = tlb_hit_raw && tlb_pte[PTE_V];

    // Outputs are computed for the state being entered, so they are registered with it.
    always_comb begin
        state_d     = state_q;
        va_d        = va_q;
        we_d        = we_q;
        wd_d        = wd_q;
        bpr_d       = bpr_q;
        pg_d        = pg_q;
        rdata_d     = rdata_q;
        ack_d       = 1'b0;
        fault_d     = 1'b0;
        mem_addr_d  = '0;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_wdata_d = '0;
        tlb_ld      = 1'b0;
        tlb_inv     = tlb_flush;
        acc         = 1'b0;
        acc_addr    = '0;
        case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    tlb_inv = 1'b1;
                    if (cfg_sel == CFG_PG) pg_d  = cfg_wdata[0];
                    else                   bpr_d = cfg_wdata[BPRW-1:0];
                end else if (req) begin
                    va_d = vaddr;
                    we_d = we;
                    wd_d = wdata;
                    if (!pg_q) begin
                        acc      = 1'b1;
                        acc_addr = {{(PAW-VAW){1'b0}}, vaddr};
                    end else if (tlb_hit && we && !tlb_pte[PTE_W]) begin
                        state_d = RESP;
                        ack_d   = 1'b1;
                        fault_d = 1'b1;
                    end else if (tlb_hit) begin
                        acc      = 1'b1;
                        acc_addr = {tlb_pte[DW-1:PPN_LSB], vaddr[OFFW-1:0]};
                    end else begin
                        state_d    = WALK;
                        mem_addr_d = {bpr_q, vaddr[VAW-1:OFFW]};
                        mem_rd_d   = 1'b1;
                    end
                end
            end
            WALK: state_d = WALK_WAIT;
            WALK_WAIT: begin
                if (!mem_rdata[PTE_V] || (we_q && !mem_rdata[PTE_W])) begin
                    state_d = RESP;
                    ack_d   = 1'b1;
                    fault_d = 1'b1;
                end else begin
                    tlb_ld   = 1'b1;
                    acc      = 1'b1;
                    acc_addr = {mem_rdata[DW-1:PPN_LSB], va_q[OFFW-1:0]};
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = RESP;
                    ack_d   = 1'b1;
                end else begin
                    state_d = READ_WAIT;
                end
            end
            READ_WAIT: begin
                rdata_d = mem_rdata;
                state_d = RESP;
                ack_d   = 1'b1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (acc) begin
            state_d     = ACCESS;
            mem_addr_d  = acc_addr;
            mem_wr_d    = we_d;
            mem_rd_d    = !we_d;
            mem_wdata_d = we_d ? wd_d : '0;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            va_q        <= '0;
            we_q        <= 1'b0;
            wd_q        <= '0;
            bpr_q       <= '0;
            pg_q        <= 1'b0;
            ack_q       <= 1'b0;
            fault_q     <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            va_q        <= va_d;
            we_q        <= we_d;
            wd_q        <= wd_d;
            bpr_q       <= bpr_d;
            pg_q        <= pg_d;
            ack_q       <= ack_d;
            fault_q     <= fault_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign ack       = ack_q;
    assign fault     = fault_q;
    assign rdata     = rdata_q;
    assign pg        = pg_q;
    assign busy      = busy_q;
    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
endmodule
